// File: rtl/ram_sp_async_read.sv
// Single-port RAM: synchronous write, combinational read on a shared address.
// Asynchronous active-low reset clears every word and holds it at zero while asserted.
module ram_sp_async_read #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  write_en,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Reset dominates the write; a held-low rst_n keeps all words at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (write_en) begin
      r_mem[address] <= data_in;
    end
  end

  assign data_out = r_mem[address];

endmodule

// File: tb/tb_ram_sp_async_read.sv
// Bench for ram_sp_async_read: vector table, random ops vs an array model,
// and hand-written sequences for reset and combinational-read corners.
`timescale 1ns/10ps
module tb_ram_sp_async_read;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic [3:0] address;
  logic       write_en;
  logic [7:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] model [16];

  ram_sp_async_read #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .address(address),
    .write_en(write_en), .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [4:0] wide_addr;
    logic [7:0] din;
    logic [7:0] exp_pre;
    logic [7:0] exp_post;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic sweep(input string nm);
    write_en = 1'b0;
    for (int a = 0; a < 16; a++) begin
      address = a[3:0];
      #0.1;
      chk($sformatf("%s[%0d]", nm, a), data_out, model[a]);
    end
  endtask

  task automatic clear_model();
    for (int a = 0; a < 16; a++) model[a] = 8'h00;
  endtask

  initial begin
    logic [7:0] rd;
    logic [3:0] ra;
    logic       rw;

    rst_n = 1'b1; write_en = 1'b0; data_in = 8'h00; address = 4'h0;

    // Reset with a write attempted on the edge while held low.
    #2 rst_n = 1'b0;
    clear_model();
    write_en = 1'b1; data_in = 8'hFF; address = 4'd3;
    @(posedge clk); #1;
    sweep("reset_sweep");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: pre-edge value shows old contents, post-edge the new word.
    vecs[0] = '{1'b1, 5'd3,  8'h24, 8'h00, 8'h24};
    vecs[1] = '{1'b0, 5'd3,  8'hFF, 8'h24, 8'h24};
    vecs[2] = '{1'b1, 5'd0,  8'hAA, 8'h00, 8'hAA};
    vecs[3] = '{1'b1, 5'd16, 8'h55, 8'hAA, 8'h55};
    vecs[4] = '{1'b1, 5'd7,  8'h81, 8'h00, 8'h81};
    vecs[5] = '{1'b1, 5'd8,  8'h09, 8'h00, 8'h09};
    vecs[6] = '{1'b0, 5'd7,  8'h00, 8'h81, 8'h81};
    vecs[7] = '{1'b1, 5'd3,  8'h11, 8'h24, 8'h11};
    vecs[8] = '{1'b1, 5'd3,  8'h22, 8'h11, 8'h22};
    vecs[9] = '{1'b0, 5'd0,  8'h99, 8'h55, 8'h55};
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      write_en = vecs[v].we;
      address  = vecs[v].wide_addr[3:0];
      data_in  = vecs[v].din;
      #1 chk($sformatf("vec%0d_pre", v), data_out, vecs[v].exp_pre);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_post", v), data_out, vecs[v].exp_post);
      if (vecs[v].we) model[vecs[v].wide_addr[3:0]] = vecs[v].din;
    end

    // Address toggling between edges: read must follow immediately.
    @(negedge clk);
    write_en = 1'b0;
    for (int t = 0; t < 8; t++) begin
      address = t[0] ? 4'd8 : 4'd7;
      #0.1;
      chk($sformatf("toggle%0d", t), data_out, t[0] ? 8'h09 : 8'h81);
      #0.3;
    end
    sweep("after_table");

    // Write every address with random data, read it back, confirm the rest.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      write_en = 1'b1; address = i[3:0]; data_in = 8'($urandom);
      @(posedge clk);
      model[i] = data_in;
      @(negedge clk);
      write_en = 1'b0; address = i[3:0];
      #0.1 chk($sformatf("rand_rb%0d", i), data_out, model[i]);
      sweep($sformatf("rand_others%0d", i));
    end

    // Random mixed traffic against the model.
    for (int k = 0; k < 200; k++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 4'($urandom);
      rd = 8'($urandom);
      @(negedge clk);
      write_en = rw; address = ra; data_in = rd;
      #1 chk("rnd_pre", data_out, model[ra]);
      @(posedge clk);
      if (rw) model[ra] = rd;
      #1 chk("rnd_post", data_out, model[ra]);
    end

    // Reset asserted between edges drops the read at once and blocks writes.
    @(negedge clk);
    write_en = 1'b1; address = 4'd5; data_in = 8'h5A;
    @(posedge clk);
    model[5] = 8'h5A;
    #1 write_en = 1'b0;
    #0.1 chk("pre_rst_a5", data_out, 8'h5A);
    #1 rst_n = 1'b0;
    clear_model();
    #0.1 chk("rst_drop_a5", data_out, 8'h00);
    write_en = 1'b1; data_in = 8'h77;
    @(posedge clk); #1;
    chk("rst_write_ignored", data_out, 8'h00);
    sweep("rst_mid_sweep");

    // First write after release lands normally.
    @(negedge clk);
    rst_n = 1'b1;
    write_en = 1'b1; address = 4'd9; data_in = 8'hC3;
    @(posedge clk);
    model[9] = 8'hC3;
    #1 chk("post_rst_write", data_out, 8'hC3);
    sweep("post_rst_sweep");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
